// File: rtl/ce_loss_batch_mean_if.sv
// Sample-in / result-out handshake bundle for ce_loss_batch_mean.
interface ce_loss_batch_mean_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  // Reduction block view
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );

  // Producer / consumer view
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

endinterface

// File: rtl/ce_loss_batch_mean.sv
// ce_loss_batch_mean: reduces each batch of per-sample losses to its mean.
// Accumulates samples, then divides sum by count with a restoring divider
// (one quotient bit per cycle, MSB first).
// Optional feature macro: CE_MEAN_ROUND_NEAREST_EN -- when defined, the mean
// is rounded half-up instead of truncated.
module ce_loss_batch_mean #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic                   clk,
  input logic                   rst,
  ce_loss_batch_mean_if.slave   s_if
);

  localparam int unsigned ACC_W = DATA_W + CNT_W;
  localparam int unsigned BIT_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_DIV = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  dvs_q, dvs_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_ovf_q, out_ovf_d;

  logic              in_fire;
  logic              close_batch;
  logic [ACC_W-1:0]  acc_new;
  logic [CNT_W-1:0]  cnt_new;
  logic [ACC_W-1:0]  dividend;
  logic [CNT_W:0]    trial;
  logic [CNT_W:0]    dvs_ext;
  logic              trial_ge;

  assign in_fire = s_if.in_valid & in_ready_q;
  assign acc_new = acc_q + ACC_W'(s_if.in_data);
  assign cnt_new = cnt_q + CNT_W'(1);

  // Batch closes on in_last or when this sample fills the counter to its maximum
  assign close_batch = s_if.in_last | (cnt_q == ~CNT_W'(1));

`ifdef CE_MEAN_ROUND_NEAREST_EN
  // Adding half the divisor turns the floor division into round-half-up
  assign dividend = acc_new + ACC_W'(cnt_new >> 1);
`else
  assign dividend = acc_new;
`endif

  // Restoring step: shift next dividend bit into the partial remainder and trial-subtract
  assign trial    = {rem_q, quo_q[ACC_W-1]};
  assign dvs_ext  = {1'b0, dvs_q};
  assign trial_ge = (trial >= dvs_ext);

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    bit_d       = bit_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      ST_ACC: begin
        if (in_fire) begin
          acc_d = acc_new;
          cnt_d = cnt_new;
          if (close_batch) begin
            quo_d   = dividend;
            rem_d   = '0;
            dvs_d   = cnt_new;
            ovf_d   = ~s_if.in_last;
            bit_d   = '0;
            state_d = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        if (bit_q == BIT_W'(ACC_W)) begin
          // All quotient bits resolved; the mean always fits DATA_W
          out_data_d  = quo_q[DATA_W-1:0];
          out_count_d = dvs_q;
          out_ovf_d   = ovf_q;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          rem_d = CNT_W'(trial_ge ? (trial - dvs_ext) : trial);
          quo_d = {quo_q[ACC_W-2:0], trial_ge};
          bit_d = bit_q + BIT_W'(1);
        end
      end
      ST_OUT: begin
        if (s_if.out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase

    in_ready_d = (state_d == ST_ACC);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      bit_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      bit_q       <= bit_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign s_if.in_ready  = in_ready_q;
  assign s_if.out_valid = out_valid_q;
  assign s_if.out_data  = out_data_q;
  assign s_if.out_count = out_count_q;
  assign s_if.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_ce_loss_batch_mean.sv
// Scoreboard bench for ce_loss_batch_mean: a default-size instance (id 0)
// and a CNT_W=3 instance (id 1) that exercises the count limit.
module tb_ce_loss_batch_mean;

`ifdef CE_MEAN_ROUND_NEAREST_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  // Close-to-valid latency is ACC_W+1 edges for each instance
  localparam int LAT0 = 32 + 16 + 1;
  localparam int LAT1 = 32 + 3 + 1;

  typedef struct {
    logic [31:0] data;
    logic [15:0] count;
    logic        ovf;
    int          close_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  int   rdy_mode;

  exp_t            q_exp0[$];
  exp_t            q_exp1[$];
  longint unsigned m_sum[2];
  int              m_cnt[2];

  logic        prev_valid[2];
  logic        prev_fire[2];
  int          rise_cyc[2];
  logic [31:0] held_data[2];
  logic [15:0] held_cnt[2];
  logic        held_ovf[2];

  ce_loss_batch_mean_if #(.DATA_W(32), .CNT_W(16)) bus ();
  ce_loss_batch_mean_if #(.DATA_W(32), .CNT_W(3))  sbus ();

  ce_loss_batch_mean #(.DATA_W(32), .CNT_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (bus)
  );

  ce_loss_batch_mean #(.DATA_W(32), .CNT_W(3)) dut_s (
    .clk  (clk),
    .rst  (rst),
    .s_if (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: mean of the batch with floor or half-up rounding
  task automatic model_push(input int id, input logic [31:0] d, input bit last, input int at);
    exp_t            e;
    longint unsigned mean;
    int              cap;
    cap = (id == 0) ? 65535 : 7;
    m_sum[id] += 64'(d);
    m_cnt[id]++;
    if (last || m_cnt[id] == cap) begin
      mean = (m_sum[id] + (ROUND ? 64'(m_cnt[id] / 2) : 64'd0)) / 64'(m_cnt[id]);
      e.data      = mean[31:0];
      e.count     = 16'(m_cnt[id]);
      e.ovf       = !last;
      e.close_cyc = at;
      if (id == 0) q_exp0.push_back(e);
      else         q_exp1.push_back(e);
      m_sum[id] = 0;
      m_cnt[id] = 0;
    end
  endtask

  // Issue one sample; caller is positioned at a falling edge
  task automatic send(input int id, input logic [31:0] d, input bit last);
    int budget;
    budget = 0;
    if (id == 0) begin bus.in_valid = 1'b1;  bus.in_data = d;  bus.in_last = last;  end
    else         begin sbus.in_valid = 1'b1; sbus.in_data = d; sbus.in_last = last; end
    while (!((id == 0) ? bus.in_ready : sbus.in_ready)) begin
      @(negedge clk);
      budget++;
      if (budget > 500) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: dut %0d in_ready stuck at 0 for %0d cycles", id, budget);
        bus.in_valid = 1'b0;
        sbus.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    @(negedge clk);
    model_push(id, d, last, cyc);
    if (id == 0) bus.in_valid = 1'b0;
    else         sbus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (q_exp0.size() != 0 || q_exp1.size() != 0) begin
      @(negedge clk);
      budget++;
      if (budget > 3000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain_timeout: %0d/%0d results still pending", q_exp0.size(), q_exp1.size());
        q_exp0.delete();
        q_exp1.delete();
        return;
      end
    end
  endtask

  // Consumer backpressure driver
  always @(negedge clk) begin
    case (rdy_mode)
      0:       begin bus.out_ready = 1'b1; sbus.out_ready = 1'b1; end
      1:       begin bus.out_ready = 1'($urandom_range(0, 1)); sbus.out_ready = 1'($urandom_range(0, 1)); end
      default: begin bus.out_ready = 1'b0; sbus.out_ready = 1'b0; end
    endcase
  end

  // Output monitor: protocol checks plus scoreboard compare on each transfer
  task automatic monitor(input int id);
    logic        v, r, o, ir;
    logic [31:0] d;
    logic [15:0] c;
    exp_t        e;
    if (id == 0) begin
      v = bus.out_valid; r = bus.out_ready; o = bus.out_ovf; ir = bus.in_ready;
      d = bus.out_data;  c = bus.out_count;
    end else begin
      v = sbus.out_valid; r = sbus.out_ready; o = sbus.out_ovf; ir = sbus.in_ready;
      d = sbus.out_data;  c = 16'(sbus.out_count);
    end
    if (rst) begin
      prev_valid[id] = 1'b0;
      prev_fire[id]  = 1'b0;
      return;
    end
    if (prev_fire[id]) begin
      chk("in_ready_after_xfer", 64'(ir), 64'd1);
      chk("valid_drop_after_xfer", 64'(v), 64'd0);
    end
    if (v && !prev_valid[id]) begin
      rise_cyc[id]  = cyc;
      held_data[id] = d;
      held_cnt[id]  = c;
      held_ovf[id]  = o;
    end else if (v) begin
      chk("hold_data", 64'(d), 64'(held_data[id]));
      chk("hold_count", 64'(c), 64'(held_cnt[id]));
      chk("hold_ovf", 64'(o), 64'(held_ovf[id]));
    end
    if (v) chk("in_ready_while_valid", 64'(ir), 64'd0);
    if (v && r) begin
      if ((id == 0 && q_exp0.size() == 0) || (id == 1 && q_exp1.size() == 0)) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: dut %0d data 0x%0h count %0d", id, d, c);
      end else begin
        e = (id == 0) ? q_exp0.pop_front() : q_exp1.pop_front();
        chk("out_data", 64'(d), 64'(e.data));
        chk("out_count", 64'(c), 64'(e.count));
        chk("out_ovf", 64'(o), 64'(e.ovf));
        chk("latency", 64'(rise_cyc[id] - e.close_cyc), 64'((id == 0) ? LAT0 : LAT1));
      end
    end
    prev_fire[id]  = v && r;
    prev_valid[id] = v;
  endtask

  always @(negedge clk) begin
    #2;
    monitor(0);
    monitor(1);
  end

  function automatic logic [31:0] rnd_sample();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 255));
      2:       return 32'hFFFF_FFFF;
      default: return 32'h0001_0000 * 32'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    logic seen;
    int   budget;
    int   len;
    int   id;
    cyc = 0; n_cmp = 0; n_fail = 0; rdy_mode = 0;
    m_sum[0] = 0; m_sum[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    prev_valid[0] = 1'b0; prev_valid[1] = 1'b0;
    prev_fire[0] = 1'b0;  prev_fire[1] = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.in_last = 1'b0;
    sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.in_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_data", 64'(bus.out_data), 64'd0);
    chk("reset_out_count", 64'(bus.out_count), 64'd0);
    chk("reset_out_ovf", 64'(bus.out_ovf), 64'd0);
    chk("reset_small_in_ready", 64'(sbus.in_ready), 64'd1);

    // Basic mean
    send(0, 32'h0001_0000, 1'b0);
    send(0, 32'h0002_0000, 1'b0);
    send(0, 32'h0003_0000, 1'b1);
    drain();

    // Rounding and single-sample batches
    send(0, 32'd1, 1'b0);
    send(0, 32'd2, 1'b1);
    send(0, 32'd5, 1'b1);
    send(1, 32'd1, 1'b0);
    send(1, 32'd2, 1'b1);
    drain();

    // Backpressure: result held for 10 cycles, then released
    rdy_mode = 2;
    send(0, 32'd100, 1'b0);
    send(0, 32'd301, 1'b1);
    budget = 0;
    while (!bus.out_valid && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("bp_valid_rose", 64'(bus.out_valid), 64'd1);
    repeat (10) @(negedge clk);
    chk("bp_valid_held", 64'(bus.out_valid), 64'd1);
    chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    rdy_mode = 0;
    drain();
    send(0, 32'd7, 1'b0);
    send(0, 32'd9, 1'b1);
    drain();

    // Extremes
    repeat (3) send(0, 32'hFFFF_FFFF, 1'b0);
    send(0, 32'hFFFF_FFFF, 1'b1);
    drain();

    // Count limit on the CNT_W=3 instance
    repeat (8) send(1, 32'h10, 1'b0);
    send(1, 32'h30, 1'b1);
    drain();

    // Randomized batches with random gaps and backpressure
    rdy_mode = 1;
    for (int b = 0; b < 24; b++) begin
      id  = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, (id == 0) ? 20 : 12));
      for (int i = 0; i < len; i++) begin
        send(id, rnd_sample(), i == len - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    drain();
    rdy_mode = 0;

    // Reset in the middle of a divide discards the batch
    send(0, 32'd1000, 1'b0);
    send(0, 32'd2000, 1'b0);
    send(0, 32'd3000, 1'b0);
    send(0, 32'd4000, 1'b1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_exp0.delete();
    q_exp1.delete();
    m_sum[0] = 0; m_cnt[0] = 0; m_sum[1] = 0; m_cnt[1] = 0;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("no_output_after_abort", 64'(seen), 64'd0);
    send(0, 32'd4, 1'b0);
    send(0, 32'd6, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ce_loss_batch_mean.md
Name: ce_loss_batch_mean

Overview:
- Downstream stage of the cross-entropy loss block. Consumes the stream of per-sample loss values and reduces each batch to its mean loss (PyTorch reduction='mean').
- Accumulates the samples of a batch, counts them, then computes sum/count with a sequential restoring divider.
- Presents the mean, the sample count and an overflow flag on a valid/ready output.

Parameters:
- DATA_W, 32, width of loss values (unsigned fixed-point; format is transparent to the block).
- CNT_W, 16, width of the sample counter. Maximum batch size is 2^CNT_W-1.
- ACC_W, DATA_W+CNT_W, accumulator and dividend width. Derived; must not be overridden.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  per-sample loss.
- in_last  in  1  marks the final sample of a batch.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  batch mean loss.
- out_count  out  CNT_W  number of samples in the batch.
- out_ovf  out  1  batch was truncated at the maximum count.

Behaviour:
- Reset: state=ACC; accumulator, counter, divider registers cleared. in_ready=1, out_valid=0, out_data=0, out_count=0, out_ovf=0.
- Reset asserted mid-batch, mid-divide or while a result is pending discards all in-flight data; the next cycle behaves as after power-on reset.
- Transfer rules: an input transfer occurs when in_valid&in_ready; an output transfer when out_valid&out_ready. in_ready is a registered function of state (1 only in ACC) and does not depend on in_valid.
- ACC state, on an input transfer: acc += zero-extended in_data; cnt += 1.
  - If in_last=1, or cnt was 2^CNT_W-2 before this increment (so the sample brings cnt to max): latch dividend=acc_new, divisor=cnt_new, ovf=(in_last==0), then go to DIV.
  - A sample closed by the count limit belongs to the current batch. The next sample starts a new batch.
- DIV state: restoring division, one quotient bit per cycle, MSB first, exactly ACC_W cycles. in_ready=0.
  - After the last bit: out_data = quotient[DATA_W-1:0], out_count = divisor, out_ovf = ovf, out_valid=1, go to OUT.
  - The quotient never exceeds 2^DATA_W-1, because the mean is at most the maximum sample value.
- OUT state: outputs held stable while out_valid=1 and out_ready=0. in_ready=0.
  - On an output transfer: out_valid=0, acc and cnt cleared, go to ACC. in_ready=1 in the following cycle.
  - out_data, out_count and out_ovf keep their last values after out_valid drops.
- Latency: a closing sample accepted at edge E sets out_valid at edge E+ACC_W+1 (49 cycles at the defaults).
- Throughput: one sample per cycle within a batch. One result per batch; minimum batch overhead is ACC_W+2 cycles.
- Batches are never empty. A batch of one sample returns that sample exactly.
- Arithmetic is unsigned. The accumulator cannot overflow, because (2^CNT_W-1)*(2^DATA_W-1) < 2^ACC_W.
- in_last is ignored when in_valid=0.

Optional Feature:
- Macro: CE_MEAN_ROUND_NEAREST_EN.
- Defined: the dividend latched on the closing sample is acc_new + (cnt_new>>1), giving round-half-up. Latency is unchanged. The ACC_W width still suffices.
- Undefined: dividend = acc_new, giving a truncating (floor) mean.

Test Plan:
- Basic mean: feed 0x00010000, 0x00020000, 0x00030000 (last on the third) → out_data=0x00020000, out_count=3, out_ovf=0. out_valid rises exactly 49 cycles after the last input edge.
- Rounding: feed 1, 2 (last) → out_data=1 without the macro, 2 with CE_MEAN_ROUND_NEAREST_EN. Feed 5 (last) → out_data=5 in both builds.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_data, out_count and out_valid stable, in_ready=0. Release → a transfer completes, in_ready=1 on the next cycle, and a new batch of 7, 9 (last) yields 8.
- Count limit (CNT_W=3): send 8 samples of 0x10 with in_last=0 → first result out_count=7, out_data=0x10, out_ovf=1. The 8th sample plus a following 0x30 (last) → out_data=0x20, out_count=2, out_ovf=0.
- Extremes: four samples of 0xFFFFFFFF (last on the fourth) → out_data=0xFFFFFFFF, out_count=4.
- Reset mid-DIV: assert rst for 1 cycle 20 cycles into a divide → out_valid stays 0, in_ready=1 the cycle after reset. A fresh batch of 4, 6 (last) yields 5 with count 2 and no residue from the aborted batch.
